// File: rtl/cr_cceip_64_df_mux_arb_if.sv
// AXI4-Stream bundle shared by the df_mux arbiter ports.
// The master drives payload and valid; the slave drives ready.
interface cr_cceip_64_df_mux_arb_if #(
    parameter int DATA_W = 64,
    parameter int USER_W = 2
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [USER_W-1:0] tuser;

    modport master (
        output tvalid,
        output tlast,
        output tdata,
        output tstrb,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tlast,
        input  tdata,
        input  tstrb,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/cr_cceip_64_df_mux_arb.sv
// Frame-granular 2:1 AXI4-S arbiter for the CCEIP-64 df_mux.
// One output register, per-port frame counters, idle flag.
module cr_cceip_64_df_mux_arb #(
    parameter int DATA_W = 64,
    parameter int USER_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg_mode,
    cr_cceip_64_df_mux_arb_if.slave  in0,
    cr_cceip_64_df_mux_arb_if.slave  in1,
    cr_cceip_64_df_mux_arb_if.master out,
    output logic             grant_port,
    output logic [CNT_W-1:0] frm_cnt0,
    output logic [CNT_W-1:0] frm_cnt1,
    output logic             arb_idle
);

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   rr_ptr;
    logic   rr_nxt;
    logic   gnt_nxt;
    logic   req0;
    logic   req1;
    logic   can_load;
    logic   acc0;
    logic   acc1;

    assign can_load = ~out.tvalid | out.tready;
    assign req0 = in0.tvalid & (cfg_mode != 2'd1);
    assign req1 = in1.tvalid & (cfg_mode != 2'd0);
    assign acc0 = in0.tvalid & in0.tready;
    assign acc1 = in1.tvalid & in1.tready;

    always_comb begin
        state_nxt  = state;
        rr_nxt     = rr_ptr;
        gnt_nxt    = grant_port;
        in0.tready = 1'b0;
        in1.tready = 1'b0;
        unique case (state)
            IDLE: begin
                // forced modes mask the other request, so rr_ptr only matters in RR
                if (req0 & (~req1 | ~rr_ptr)) begin
                    state_nxt = GNT0;
                    gnt_nxt   = 1'b0;
                end else if (req1) begin
                    state_nxt = GNT1;
                    gnt_nxt   = 1'b1;
                end
            end
            GNT0: begin
                in0.tready = can_load;
                if (in0.tvalid & can_load & in0.tlast) begin
                    state_nxt = IDLE;
                    rr_nxt    = 1'b1;
                end
            end
            GNT1: begin
                in1.tready = can_load;
                if (in1.tvalid & can_load & in1.tlast) begin
                    state_nxt = IDLE;
                    rr_nxt    = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            grant_port <= 1'b0;
            frm_cnt0   <= '0;
            frm_cnt1   <= '0;
            arb_idle   <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_nxt;
            grant_port <= gnt_nxt;
            arb_idle   <= (state == IDLE) & ~out.tvalid
                        & ~in0.tvalid & ~in1.tvalid;
            if (acc0 & in0.tlast)
                frm_cnt0 <= frm_cnt0 + CNT_W'(1);
            if (acc1 & in1.tlast)
                frm_cnt1 <= frm_cnt1 + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out.tvalid <= 1'b0;
            out.tlast  <= 1'b0;
            out.tdata  <= '0;
            out.tstrb  <= '0;
            out.tuser  <= '0;
        end else if (acc0 | acc1) begin
            out.tvalid <= 1'b1;
            out.tlast  <= acc1 ? in1.tlast : in0.tlast;
            out.tdata  <= acc1 ? in1.tdata : in0.tdata;
            out.tstrb  <= acc1 ? in1.tstrb : in0.tstrb;
            out.tuser  <= acc1 ? in1.tuser : in0.tuser;
        end else if (out.tready) begin
            out.tvalid <= 1'b0;
        end
    end

endmodule
